// File: rtl/frag_sched_pkg.sv
// Shared types for the fragment/texture scheduler: FSM states and the default
// colour-vector layout.
package frag_sched_pkg;

    localparam int unsigned FRAG_DATA_WIDTH = 32;
    localparam int unsigned FRAG_VEC_SIZE   = 4;

    typedef enum logic [0:0] {
        SCHED_RUN   = 1'b0,
        SCHED_DRAIN = 1'b1
    } sched_state_e;

    typedef logic [FRAG_VEC_SIZE-1:0][FRAG_DATA_WIDTH-1:0] color_vec_t;

endpackage

// File: rtl/frag_color_fifo.sv
// In-order colour FIFO with a registered first-word-fall-through head.
module frag_color_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = head_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_next = rd_ptr_q + PTR_W'(1);

    // Head register always holds the entry that will be oldest after this edge.
    always_comb begin
        head_d = head_q;
        if (do_pop) begin
            if (count_q > CNT_W'(1)) begin
                head_d = mem[rd_next];
            end else if (do_push) begin
                head_d = wdata;
            end
        end else if (empty && do_push) begin
            head_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_next;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/frag_tex_scheduler.sv
// Issues one texture fetch per fragment, parks colours in order and pairs each
// returned texel with its colour for the fragment shader.
module frag_tex_scheduler
    import frag_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned VEC_SIZE        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_frag_valid,
    output logic                                 o_frag_ready,
    input  logic [VEC_SIZE*DATA_WIDTH-1:0]       i_frag_color,
    input  logic [2*DATA_WIDTH-1:0]              i_frag_tex_coord,
    output logic                                 o_tex_req_valid,
    input  logic                                 i_tex_req_ready,
    output logic [2*DATA_WIDTH-1:0]              o_tex_req_coord,
    input  logic                                 i_tex_resp_valid,
    input  logic [VEC_SIZE*DATA_WIDTH-1:0]       i_tex_resp_texel,
    output logic                                 o_shade_valid,
    output logic [VEC_SIZE*DATA_WIDTH-1:0]       o_shade_color,
    output logic [VEC_SIZE*DATA_WIDTH-1:0]       o_shade_texel,
    input  logic                                 i_flush,
    output logic                                 o_flush_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
    output logic                                 o_err_timeout,
    output logic                                 o_err_spurious
);

    localparam int unsigned COLOR_W = VEC_SIZE * DATA_WIDTH;
    localparam int unsigned COORD_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_e       state_q;
    sched_state_e       state_d;
    logic               drain_done;

    logic               req_valid_q;
    logic [COORD_W-1:0] req_coord_q;

    logic               accept;
    logic               pop;
    logic               spurious;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [COLOR_W-1:0] fifo_rdata;

    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    logic               timeout_hit;
    logic               err_timeout_q;
    logic               err_spurious_q;

    logic               shade_valid_q;
    logic [COLOR_W-1:0] shade_color_q;
    logic [COLOR_W-1:0] shade_texel_q;

    // Outstanding count equals FIFO occupancy, so "full" is the outstanding limit.
    assign o_frag_ready = rst_n && (state_q == SCHED_RUN) && !fifo_full
                          && (!req_valid_q || i_tex_req_ready);
    assign accept       = i_frag_valid && o_frag_ready;
    assign pop          = i_tex_resp_valid && !fifo_empty;
    assign spurious     = i_tex_resp_valid && fifo_empty;

    frag_color_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (COLOR_W)
    ) u_color_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (i_frag_color),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .rdata (fifo_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SCHED_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain completes once nothing is queued for or waiting on the texture unit.
    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            SCHED_RUN: begin
                if (i_flush) begin
                    state_d = SCHED_DRAIN;
                end
            end
            SCHED_DRAIN: begin
                if ((fifo_count == '0) && !req_valid_q) begin
                    state_d    = SCHED_RUN;
                    drain_done = 1'b1;
                end
            end
            default: state_d = SCHED_RUN;
        endcase
    end

    // Stall timer: counts idle cycles while fetches are in flight.
    always_comb begin
        timer_d = timer_q;
        if (i_tex_resp_valid || (fifo_count == '0)) begin
            timer_d = '0;
        end else if (timer_q < TMR_W'(TIMEOUT_CYCLES)) begin
            timer_d = timer_q + TMR_W'(1);
        end
        timeout_hit = (timer_d == TMR_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_valid_q    <= 1'b0;
            req_coord_q    <= '0;
            timer_q        <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
            shade_valid_q  <= 1'b0;
            shade_color_q  <= '0;
            shade_texel_q  <= '0;
        end else begin
            if (accept) begin
                req_valid_q <= 1'b1;
                req_coord_q <= i_frag_tex_coord;
            end else if (i_tex_req_ready) begin
                req_valid_q <= 1'b0;
            end
            timer_q <= timer_d;
            if (timeout_hit) begin
                err_timeout_q <= 1'b1;
            end
            if (spurious) begin
                err_spurious_q <= 1'b1;
            end
            shade_valid_q <= pop;
            if (pop) begin
                shade_color_q <= fifo_rdata;
                shade_texel_q <= i_tex_resp_texel;
            end
        end
    end

    assign o_tex_req_valid = req_valid_q;
    assign o_tex_req_coord = req_coord_q;
    assign o_shade_valid   = shade_valid_q;
    assign o_shade_color   = shade_color_q;
    assign o_shade_texel   = shade_texel_q;
    assign o_flush_done    = drain_done;
    assign o_outstanding   = fifo_count;
    assign o_err_timeout   = err_timeout_q;
    assign o_err_spurious  = err_spurious_q;

endmodule

// File: tb/tb_frag_tex_scheduler.sv
// Directed bench for frag_tex_scheduler: cycle table plus multi-cycle scenarios.
module tb_frag_tex_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frag_valid;
    logic         frag_ready;
    logic [127:0] frag_color;
    logic [63:0]  frag_coord;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_coord;
    logic         resp_valid;
    logic [127:0] resp_texel;
    logic         shade_valid;
    logic [127:0] shade_color;
    logic [127:0] shade_texel;
    logic         flush;
    logic         flush_done;
    logic [2:0]   outstanding;
    logic         err_timeout;
    logic         err_spurious;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    frag_tex_scheduler #(
        .DATA_WIDTH      (32),
        .VEC_SIZE        (4),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_frag_valid     (frag_valid),
        .o_frag_ready     (frag_ready),
        .i_frag_color     (frag_color),
        .i_frag_tex_coord (frag_coord),
        .o_tex_req_valid  (req_valid),
        .i_tex_req_ready  (req_ready),
        .o_tex_req_coord  (req_coord),
        .i_tex_resp_valid (resp_valid),
        .i_tex_resp_texel (resp_texel),
        .o_shade_valid    (shade_valid),
        .o_shade_color    (shade_color),
        .o_shade_texel    (shade_texel),
        .i_flush          (flush),
        .o_flush_done     (flush_done),
        .o_outstanding    (outstanding),
        .o_err_timeout    (err_timeout),
        .o_err_spurious   (err_spurious)
    );

    typedef struct {
        logic         fv;
        logic [127:0] col;
        logic [63:0]  crd;
        logic         rr;
        logic         rv;
        logic [127:0] tex;
        logic         e_ready;
        logic         e_rqv;
        logic [63:0]  e_crd;
        logic         e_sv;
        logic [127:0] e_col;
        logic [127:0] e_tex;
        logic [2:0]   e_out;
        logic         e_spur;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [127:0] c4(input int a, input int b, input int c, input int d);
        return {32'(a), 32'(b), 32'(c), 32'(d)};
    endfunction

    function automatic logic [63:0] uv(input int u, input int v);
        return {32'(u), 32'(v)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        frag_valid = 1'b0;
        frag_color = '0;
        frag_coord = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_texel = '0;
        flush      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"},   128'(frag_ready), 128'(0));
        chk({tag, "_reqv"},    128'(req_valid), 128'(0));
        chk({tag, "_reqc"},    128'(req_coord), 128'(0));
        chk({tag, "_sv"},      128'(shade_valid), 128'(0));
        chk({tag, "_scol"},    shade_color, 128'(0));
        chk({tag, "_stex"},    shade_texel, 128'(0));
        chk({tag, "_done"},    128'(flush_done), 128'(0));
        chk({tag, "_out"},     128'(outstanding), 128'(0));
        chk({tag, "_etmo"},    128'(err_timeout), 128'(0));
        chk({tag, "_espur"},   128'(err_spurious), 128'(0));
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("rst");
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic fv, input logic [127:0] col, input logic [63:0] crd,
                                input logic rr, input logic rv, input logic [127:0] tex,
                                input logic e_ready, input logic e_rqv, input logic [63:0] e_crd,
                                input logic e_sv, input logic [127:0] e_col, input logic [127:0] e_tex,
                                input logic [2:0] e_out, input logic e_spur);
        vec_t v;
        v.fv = fv; v.col = col; v.crd = crd; v.rr = rr; v.rv = rv; v.tex = tex;
        v.e_ready = e_ready; v.e_rqv = e_rqv; v.e_crd = e_crd; v.e_sv = e_sv;
        v.e_col = e_col; v.e_tex = e_tex; v.e_out = e_out; v.e_spur = e_spur;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [127:0] c1, t1, ca, cb, cc, cd, ta, tb, tc, td, z;
        logic [63:0]  k1, ka, kb, kc, kd;
        int n_acc;
        int pulses;
        c1 = c4(1, 2, 3, 4);    t1 = c4(2, 2, 2, 2);    k1 = uv(5, 6);
        ca = c4(10, 11, 12, 13); ka = uv(20, 21); ta = c4(30, 31, 32, 33);
        cb = c4(40, 41, 42, 43); kb = uv(50, 51); tb = c4(60, 61, 62, 63);
        cc = c4(70, 71, 72, 73); kc = uv(80, 81); tc = c4(90, 91, 92, 93);
        cd = c4(7, 7, 7, 7);     kd = uv(8, 9);   td = c4(9, 9, 9, 9);
        z  = '0;

        // fv col crd rr rv tex | ready rqv crd sv col tex out spur
        vecs[0]  = mk(1, c1, k1, 1, 0, z,              1, 1, k1, 0, z,  z,  3'd1, 0);
        vecs[1]  = mk(0, z,  0,  1, 0, z,              1, 0, 0,  0, z,  z,  3'd1, 0);
        vecs[2]  = mk(0, z,  0,  1, 0, z,              1, 0, 0,  0, z,  z,  3'd1, 0);
        vecs[3]  = mk(0, z,  0,  1, 0, z,              1, 0, 0,  0, z,  z,  3'd1, 0);
        vecs[4]  = mk(0, z,  0,  1, 1, t1,             1, 0, 0,  1, c1, t1, 3'd0, 0);
        vecs[5]  = mk(0, z,  0,  1, 0, z,              1, 0, 0,  0, c1, t1, 3'd0, 0);
        vecs[6]  = mk(1, ca, ka, 1, 0, z,              1, 1, ka, 0, c1, t1, 3'd1, 0);
        vecs[7]  = mk(1, cb, kb, 1, 0, z,              1, 1, kb, 0, c1, t1, 3'd2, 0);
        vecs[8]  = mk(1, cc, kc, 1, 1, ta,             1, 1, kc, 1, ca, ta, 3'd2, 0);
        vecs[9]  = mk(0, z,  0,  1, 1, tb,             1, 0, 0,  1, cb, tb, 3'd1, 0);
        vecs[10] = mk(0, z,  0,  1, 1, tc,             1, 0, 0,  1, cc, tc, 3'd0, 0);
        vecs[11] = mk(0, z,  0,  1, 1, c4(5,5,5,5),    1, 0, 0,  0, cc, tc, 3'd0, 1);
        vecs[12] = mk(1, cd, kd, 0, 1, c4(6,6,6,6),    1, 1, kd, 0, cc, tc, 3'd1, 1);
        vecs[13] = mk(0, z,  0,  1, 0, z,              1, 0, 0,  0, cc, tc, 3'd1, 1);
        vecs[14] = mk(0, z,  0,  1, 1, td,             1, 0, 0,  1, cd, td, 3'd0, 1);

        idle();
        rst_n = 1'b0;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            frag_valid = vecs[i].fv;
            frag_color = vecs[i].col;
            frag_coord = vecs[i].crd;
            req_ready  = vecs[i].rr;
            resp_valid = vecs[i].rv;
            resp_texel = vecs[i].tex;
            #1;
            chk($sformatf("v%0d_ready", i), 128'(frag_ready), 128'(vecs[i].e_ready));
            tick();
            chk($sformatf("v%0d_reqv", i), 128'(req_valid), 128'(vecs[i].e_rqv));
            if (vecs[i].e_rqv) chk($sformatf("v%0d_reqc", i), 128'(req_coord), 128'(vecs[i].e_crd));
            chk($sformatf("v%0d_sv", i),   128'(shade_valid), 128'(vecs[i].e_sv));
            chk($sformatf("v%0d_scol", i), shade_color, vecs[i].e_col);
            chk($sformatf("v%0d_stex", i), shade_texel, vecs[i].e_tex);
            chk($sformatf("v%0d_out", i),  128'(outstanding), 128'(vecs[i].e_out));
            chk($sformatf("v%0d_espur", i), 128'(err_spurious), 128'(vecs[i].e_spur));
            chk($sformatf("v%0d_etmo", i), 128'(err_timeout), 128'(0));
        end
        idle();

        // Fill to the outstanding limit, then release one slot.
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            frag_valid = 1'b1;
            frag_color = c4(100 + n_acc, 0, 0, 1);
            frag_coord = uv(n_acc, n_acc);
            req_ready  = 1'b1;
            #1;
            if (frag_ready) n_acc++;
            tick();
        end
        chk("fill_accepted", 128'(n_acc), 128'(4));
        chk("fill_out", 128'(outstanding), 128'(4));
        #1;
        chk("fill_ready_low", 128'(frag_ready), 128'(0));
        frag_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            resp_valid = 1'b1;
            resp_texel = c4(200 + j, 0, 0, 0);
            tick();
            chk($sformatf("fill_sv%0d", j), 128'(shade_valid), 128'(1));
            chk($sformatf("fill_col%0d", j), shade_color, c4(100 + j, 0, 0, 1));
            chk($sformatf("fill_tex%0d", j), shade_texel, c4(200 + j, 0, 0, 0));
            if (j == 0) chk("fill_ready_back", 128'(frag_ready), 128'(1));
        end
        resp_valid = 1'b0;
        tick();
        chk("fill_out_end", 128'(outstanding), 128'(0));

        // Texture request backpressure.
        do_reset();
        frag_valid = 1'b1; frag_color = ca; frag_coord = ka; req_ready = 1'b0;
        #1;
        chk("bp_ready_first", 128'(frag_ready), 128'(1));
        tick();
        frag_color = cb; frag_coord = kb;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("bp_ready%0d", s), 128'(frag_ready), 128'(0));
            tick();
            chk($sformatf("bp_reqv%0d", s), 128'(req_valid), 128'(1));
            chk($sformatf("bp_reqc%0d", s), 128'(req_coord), 128'(ka));
            chk($sformatf("bp_out%0d", s), 128'(outstanding), 128'(1));
        end
        req_ready = 1'b1;
        #1;
        chk("bp_ready_release", 128'(frag_ready), 128'(1));
        tick();
        chk("bp_reqc_second", 128'(req_coord), 128'(kb));
        chk("bp_out_two", 128'(outstanding), 128'(2));
        frag_valid = 1'b0;
        resp_valid = 1'b1; resp_texel = ta;
        tick();
        chk("bp_col_a", shade_color, ca);
        resp_texel = tb;
        tick();
        chk("bp_col_b", shade_color, cb);
        chk("bp_tex_b", shade_texel, tb);
        resp_valid = 1'b0;
        chk("bp_out_end", 128'(outstanding), 128'(0));

        // Flush with three fetches in flight.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            frag_valid = 1'b1; frag_color = c4(300 + f, 1, 1, 1); frag_coord = uv(f, 9); req_ready = 1'b1;
            tick();
        end
        frag_valid = 1'b0;
        flush = 1'b1;
        tick();
        frag_valid = 1'b1; frag_color = c4(999, 0, 0, 0);
        #1;
        chk("fl_ready_low", 128'(frag_ready), 128'(0));
        tick();
        chk("fl_out_held", 128'(outstanding), 128'(3));
        frag_valid = 1'b0;
        pulses = 0;
        for (int r = 0; r < 3; r++) begin
            resp_valid = 1'b1; resp_texel = c4(400 + r, 0, 0, 0);
            tick();
            resp_valid = 1'b0;
            #1;
            chk($sformatf("fl_col%0d", r), shade_color, c4(300 + r, 1, 1, 1));
            chk($sformatf("fl_done%0d", r), 128'(flush_done), 128'(r == 2));
            if (flush_done) pulses++;
        end
        flush = 1'b0;
        tick();
        if (flush_done) pulses++;
        chk("fl_ready_run", 128'(frag_ready), 128'(1));
        tick();
        if (flush_done) pulses++;
        chk("fl_pulses", 128'(pulses), 128'(1));

        // Spurious response and stall timeout.
        do_reset();
        resp_valid = 1'b1; resp_texel = tc;
        tick();
        resp_valid = 1'b0;
        chk("er_spur", 128'(err_spurious), 128'(1));
        chk("er_spur_sv", 128'(shade_valid), 128'(0));
        chk("er_spur_out", 128'(outstanding), 128'(0));
        do_reset();
        frag_valid = 1'b1; frag_color = cc; frag_coord = kc; req_ready = 1'b1;
        tick();
        frag_valid = 1'b0;
        repeat (7) tick();
        chk("er_tmo_before", 128'(err_timeout), 128'(0));
        tick();
        chk("er_tmo_set", 128'(err_timeout), 128'(1));
        resp_valid = 1'b1; resp_texel = tc;
        tick();
        resp_valid = 1'b0;
        chk("er_tmo_sv", 128'(shade_valid), 128'(1));
        chk("er_tmo_col", shade_color, cc);
        chk("er_tmo_sticky", 128'(err_timeout), 128'(1));

        // Reset in the middle of a stream.
        do_reset();
        frag_valid = 1'b1; frag_color = ca; frag_coord = ka; req_ready = 1'b1;
        tick();
        frag_color = cb; frag_coord = kb;
        tick();
        idle();
        chk("mr_out_two", 128'(outstanding), 128'(2));
        rst_n = 1'b0;
        tick();
        check_all_zero("mr");
        rst_n = 1'b1;
        resp_valid = 1'b1; resp_texel = ta;
        tick();
        resp_valid = 1'b0;
        chk("mr_late_spur", 128'(err_spurious), 128'(1));
        chk("mr_late_sv", 128'(shade_valid), 128'(0));
        frag_valid = 1'b1; frag_color = cd; frag_coord = kd; req_ready = 1'b1;
        tick();
        frag_valid = 1'b0;
        chk("mr_reqc", 128'(req_coord), 128'(kd));
        resp_valid = 1'b1; resp_texel = td;
        tick();
        resp_valid = 1'b0;
        chk("mr_sv", 128'(shade_valid), 128'(1));
        chk("mr_col", shade_color, cd);
        chk("mr_tex", shade_texel, td);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
